// File: rtl/rob_pkg.sv
// -----------------------------------------------------------------------------
// rob_pkg
// Shared definitions for the ROB writeback-port arbiter.
//   - Field offsets inside a packed writeback entry, MSB first:
//       {slot_id, dest_addr[2:0], result[15:0], pc[15:0], ex_vector[1:0],
//        we, ticket_we}
//     Everything below slot_id is fixed at 39 bits, so slot_id starts at
//     bit 39 whatever the ROB size is.
//   - Grant encoding used by the arbiter and as the requester index.
// -----------------------------------------------------------------------------
package rob_pkg;

   // Default slot-id width; the top re-exposes it as a parameter
   localparam int DEF_SLOT_W = 3;

   localparam int TWE_BIT    = 0;
   localparam int WE_BIT     = 1;
   localparam int EXV_LSB    = 2;
   localparam int PC_LSB     = 4;
   localparam int RESULT_LSB = 20;
   localparam int ADDR_LSB   = 36;
   localparam int SLOT_LSB   = 39;
   localparam int SLOT_MSB   = SLOT_LSB + DEF_SLOT_W - 1;

   // Grant codes double as the requester index (0 = short, 1 = long)
   localparam logic GRANT_SP = 1'b0;
   localparam logic GRANT_LP = 1'b1;

endpackage : rob_pkg

// File: rtl/wb_result_fifo.sv
// -----------------------------------------------------------------------------
// wb_result_fifo
// Small circular FIFO buffering completed results of one pipeline until the
// ROB writeback port is free.
//   clk, reset       : clock, synchronous active-high reset
//   i_flush          : empties the FIFO; a same-cycle push is discarded
//   i_push, i_entry  : push request and data
//   i_pop            : remove the head entry (ignored when empty)
//   o_head           : current head entry (valid when !o_empty)
//   o_count          : occupancy, 0..QDEPTH
//   o_full, o_empty  : occupancy flags
//   o_almost_full    : occupancy >= QDEPTH-1, used to throttle issue
// A push into a full FIFO is accepted only when the head pops in the same
// cycle; otherwise it is silently dropped (the parent flags that).
// -----------------------------------------------------------------------------
module wb_result_fifo #(
   parameter int QDEPTH     = 4,
   parameter int LOG_QDEPTH = 2,
   parameter int ENTRY_W    = 42
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_flush,
   input  logic                  i_push,
   input  logic [ENTRY_W-1:0]    i_entry,
   input  logic                  i_pop,
   output logic [ENTRY_W-1:0]    o_head,
   output logic [LOG_QDEPTH:0]   o_count,
   output logic                  o_full,
   output logic                  o_empty,
   output logic                  o_almost_full
);

   localparam int CW = LOG_QDEPTH + 1;

   logic [ENTRY_W-1:0]    r_mem [QDEPTH];
   logic [LOG_QDEPTH-1:0] r_wr_ptr;
   logic [LOG_QDEPTH-1:0] r_rd_ptr;
   logic [CW-1:0]         r_count;

   logic w_push_ok;
   logic w_pop_ok;

   assign o_full        = (r_count == CW'(QDEPTH));
   assign o_empty       = (r_count == '0);
   assign o_almost_full = (r_count >= CW'(QDEPTH - 1));
   assign o_count       = r_count;

   assign w_pop_ok  = i_pop && !o_empty;
   // The slot freed by a same-cycle pop lets a full FIFO take the push
   assign w_push_ok = i_push && (!o_full || w_pop_ok);

   always_ff @(posedge clk) begin
      if (reset || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + LOG_QDEPTH'(1);
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + LOG_QDEPTH'(1);
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage carries no reset; only entries below r_count are ever read out
   always_ff @(posedge clk) begin
      if (!reset && !i_flush && w_push_ok) begin
         r_mem[r_wr_ptr] <= i_entry;
      end
   end

   // Head is read combinationally so the arbiter can pop it in the same cycle
   assign o_head = r_mem[r_rd_ptr];

endmodule : wb_result_fifo

// File: rtl/rob_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// rob_wb_port_arbiter
// Shares the single ROB writeback port between the short pipeline (sp) and
// the long pipeline (lp). Each pipeline pushes into its own wb_result_fifo;
// a round-robin arbiter with full-queue priority drains one entry per cycle
// into a registered ROB write port.
//   clk, reset                 : clock, synchronous active-high reset
//   flush                      : exception flush, drops every buffered result
//   sp_valid, sp_entry         : short-pipeline result push
//   lp_valid, lp_entry         : long-pipeline result push
//   rob_valid, rob_entry       : registered ROB write strobe and data
//   rob_from_lp                : source of the current rob_entry (1 = lp)
//   sp_almost_full/lp_almost_full : issue throttle, occupancy >= QDEPTH-1
//   overflow_err               : sticky, set when a push was dropped
// -----------------------------------------------------------------------------
module rob_wb_port_arbiter
   import rob_pkg::*;
#(
   parameter int LOG_ROB_NUM_REGS = DEF_SLOT_W,
   parameter int QDEPTH           = 4,
   parameter int LOG_QDEPTH       = 2,
   parameter int ENTRY_W          = LOG_ROB_NUM_REGS + SLOT_LSB
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   input  logic                sp_valid,
   input  logic [ENTRY_W-1:0]  sp_entry,
   input  logic                lp_valid,
   input  logic [ENTRY_W-1:0]  lp_entry,
   output logic                rob_valid,
   output logic [ENTRY_W-1:0]  rob_entry,
   output logic                rob_from_lp,
   output logic                sp_almost_full,
   output logic                lp_almost_full,
   output logic                overflow_err
);

   localparam int CW   = LOG_QDEPTH + 1;
   localparam int NREQ = 2;

   // Requester vectors are indexed by grant code: [0] = sp, [1] = lp
   logic [NREQ-1:0]    w_push;
   logic [NREQ-1:0]    w_pop;
   logic [NREQ-1:0]    w_full;
   logic [NREQ-1:0]    w_empty;
   logic [NREQ-1:0]    w_afull;
   logic [NREQ-1:0]    w_drop;
   logic [ENTRY_W-1:0] w_in   [NREQ];
   logic [ENTRY_W-1:0] w_head [NREQ];
   logic [CW-1:0]      w_count[NREQ];

   logic               w_grant_valid;
   logic               w_grant_src;

   logic               r_last_grant;
   logic               r_rob_valid;
   logic [ENTRY_W-1:0] r_rob_entry;
   logic               r_rob_from_lp;
   logic               r_overflow;

   assign w_push[0] = sp_valid;
   assign w_push[1] = lp_valid;
   assign w_in[0]   = sp_entry;
   assign w_in[1]   = lp_entry;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_fifo
         wb_result_fifo #(
            .QDEPTH     (QDEPTH),
            .LOG_QDEPTH (LOG_QDEPTH),
            .ENTRY_W    (ENTRY_W)
         ) u_fifo (
            .clk           (clk),
            .reset         (reset),
            .i_flush       (flush),
            .i_push        (w_push[gi]),
            .i_entry       (w_in[gi]),
            .i_pop         (w_pop[gi]),
            .o_head        (w_head[gi]),
            .o_count       (w_count[gi]),
            .o_full        (w_full[gi]),
            .o_empty       (w_empty[gi]),
            .o_almost_full (w_afull[gi])
         );

         // A push is lost only when the queue stays full through the edge;
         // pushes discarded by a flush are intentional and not errors
         assign w_drop[gi] = w_push[gi] && (w_count[gi] == CW'(QDEPTH)) &&
                             !w_pop[gi] && !flush;

         assign w_pop[gi]  = w_grant_valid && (w_grant_src == gi[0]);
      end
   endgenerate

   // Arbitration on the FIFO state at the start of the cycle. A full queue
   // beats a non-full one so it frees a slot before the next push is lost;
   // otherwise strict alternation against the last actual grant.
   always_comb begin
      w_grant_valid = 1'b0;
      w_grant_src   = ~r_last_grant;
      if (!flush) begin
         if (!w_empty[0] && !w_empty[1]) begin
            w_grant_valid = 1'b1;
            if (w_full[0] && !w_full[1]) begin
               w_grant_src = GRANT_SP;
            end else if (w_full[1] && !w_full[0]) begin
               w_grant_src = GRANT_LP;
            end else begin
               w_grant_src = ~r_last_grant;
            end
         end else if (!w_empty[0]) begin
            w_grant_valid = 1'b1;
            w_grant_src   = GRANT_SP;
         end else if (!w_empty[1]) begin
            w_grant_valid = 1'b1;
            w_grant_src   = GRANT_LP;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_last_grant  <= GRANT_LP;
         r_rob_valid   <= 1'b0;
         r_rob_entry   <= '0;
         r_rob_from_lp <= 1'b0;
         r_overflow    <= 1'b0;
      end else begin
         r_rob_valid <= w_grant_valid;
         r_overflow  <= r_overflow | (|w_drop);
         // rob_entry/rob_from_lp hold their last value on idle cycles
         if (w_grant_valid) begin
            r_rob_entry   <= w_head[w_grant_src];
            r_rob_from_lp <= w_grant_src;
            r_last_grant  <= w_grant_src;
         end
      end
   end

   assign rob_valid      = r_rob_valid;
   assign rob_entry      = r_rob_entry;
   assign rob_from_lp    = r_rob_from_lp;
   assign sp_almost_full = w_afull[0];
   assign lp_almost_full = w_afull[1];
   assign overflow_err   = r_overflow;

endmodule : rob_wb_port_arbiter

// File: tb/tb_rob_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rob_wb_port_arbiter
// Directed-vector bench for rob_wb_port_arbiter. Inputs change 1 ns after a
// rising edge; outputs are sampled at that same point, i.e. they show the
// state registered at the preceding edge.
// -----------------------------------------------------------------------------
module tb_rob_wb_port_arbiter;
   import rob_pkg::*;

   localparam int EW = DEF_SLOT_W + SLOT_LSB;

   logic          clk = 1'b0;
   logic          reset;
   logic          flush;
   logic          sp_valid;
   logic [EW-1:0] sp_entry;
   logic          lp_valid;
   logic [EW-1:0] lp_entry;
   logic          rob_valid;
   logic [EW-1:0] rob_entry;
   logic          rob_from_lp;
   logic          sp_almost_full;
   logic          lp_almost_full;
   logic          overflow_err;

   int n_checks = 0;
   int n_fail   = 0;

   // Hand-derived expectations for the interleave and fill scenarios.
   // Entry k describes the ROB port just after edge k+1: src -1 = idle,
   // 0 = sp, 1 = lp; idx = push order within that source.
   int il_src [8]  = '{-1, 0, 1, 0, 1, 0, 1, -1};
   int il_idx [8]  = '{ 0, 0, 0, 1, 1, 2, 2,  0};
   int fl_lpv [11] = '{ 1, 1, 0, 1, 0, 1, 0, 1, 1, 1, 0};
   int fl_src [11] = '{-1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 1};
   int fl_idx [11] = '{ 0, 0, 0, 1, 1, 2, 2, 3, 4, 5, 3};
   int fl_spaf[11] = '{ 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
   int fl_lpaf[11] = '{ 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
   int fl_ovf [11] = '{ 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

   rob_wb_port_arbiter dut (
      .clk            (clk),
      .reset          (reset),
      .flush          (flush),
      .sp_valid       (sp_valid),
      .sp_entry       (sp_entry),
      .lp_valid       (lp_valid),
      .lp_entry       (lp_entry),
      .rob_valid      (rob_valid),
      .rob_entry      (rob_entry),
      .rob_from_lp    (rob_from_lp),
      .sp_almost_full (sp_almost_full),
      .lp_almost_full (lp_almost_full),
      .overflow_err   (overflow_err)
   );

   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   function automatic logic [EW-1:0] mk(input logic [2:0] slot, input logic [15:0] res);
      logic [EW-1:0] e;
      e                        = '0;
      e[SLOT_MSB:SLOT_LSB]     = slot;
      e[ADDR_LSB +: 3]         = slot;
      e[RESULT_LSB +: 16]      = res;
      e[PC_LSB +: 16]          = ~res;
      e[EXV_LSB +: 2]          = 2'b10;
      e[WE_BIT]                = 1'b1;
      return e;
   endfunction

   task automatic cyc(input logic sv, input logic [EW-1:0] se,
                      input logic lv, input logic [EW-1:0] le, input logic fl);
      sp_valid = sv;
      sp_entry = se;
      lp_valid = lv;
      lp_entry = le;
      flush    = fl;
      @(posedge clk);
      #1;
      sp_valid = 1'b0;
      lp_valid = 1'b0;
      flush    = 1'b0;
   endtask

   task automatic idle();
      cyc(1'b0, '0, 1'b0, '0, 1'b0);
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      flush    = 1'b0;
      sp_valid = 1'b0;
      lp_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic exp_rob(input string tag, input logic v, input logic src,
                          input logic [2:0] slot, input logic [15:0] res);
      chk_eq({tag, ".rob_valid"}, 64'(rob_valid), 64'(v));
      if (v) begin
         chk_eq({tag, ".rob_from_lp"}, 64'(rob_from_lp), 64'(src));
         chk_eq({tag, ".slot"}, 64'(rob_entry[SLOT_MSB:SLOT_LSB]), 64'(slot));
         chk_eq({tag, ".result"}, 64'(rob_entry[RESULT_LSB +: 16]), 64'(res));
      end
   endtask

   // sp entry idx carries slot idx, lp entry idx carries slot 4+idx
   task automatic exp_pop(input string tag, input int src, input int idx,
                          input logic [15:0] sp_base, input logic [15:0] lp_base);
      if (src < 0) begin
         chk_eq({tag, ".rob_valid"}, 64'(rob_valid), 64'd0);
      end else if (src == 0) begin
         exp_rob(tag, 1'b1, 1'b0, 3'(idx), sp_base + 16'(idx));
      end else begin
         exp_rob(tag, 1'b1, 1'b1, 3'(4 + idx), lp_base + 16'(idx));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired got=running expected=finished");
      $fatal(1);
   end

   initial begin
      int lp_j;
      reset    = 1'b1;
      flush    = 1'b0;
      sp_valid = 1'b0;
      lp_valid = 1'b0;
      sp_entry = '0;
      lp_entry = '0;

      // ---------------- reset + idle ----------------
      do_reset();
      repeat (5) idle();
      chk_eq("rst.rob_valid",      64'(rob_valid), 64'd0);
      chk_eq("rst.rob_entry",      64'(rob_entry), 64'd0);
      chk_eq("rst.rob_from_lp",    64'(rob_from_lp), 64'd0);
      chk_eq("rst.sp_almost_full", 64'(sp_almost_full), 64'd0);
      chk_eq("rst.lp_almost_full", 64'(lp_almost_full), 64'd0);
      chk_eq("rst.overflow_err",   64'(overflow_err), 64'd0);

      // ---------------- single sp push, 2-cycle latency ----------------
      do_reset();
      cyc(1'b1, mk(3'd3, 16'hBEEF), 1'b0, '0, 1'b0);
      chk_eq("single.e1.rob_valid", 64'(rob_valid), 64'd0);
      idle();
      exp_rob("single.e2", 1'b1, 1'b0, 3'd3, 16'hBEEF);
      idle();
      chk_eq("single.e3.rob_valid", 64'(rob_valid), 64'd0);
      chk_eq("single.e3.hold_slot", 64'(rob_entry[SLOT_MSB:SLOT_LSB]), 64'd3);

      // ---------------- simultaneous sp+lp, round robin ----------------
      do_reset();
      for (int k = 0; k < 8; k++) begin
         if (k < 3) begin
            cyc(1'b1, mk(3'(k), 16'h1000 + 16'(k)),
                1'b1, mk(3'(4 + k), 16'h2000 + 16'(k)), 1'b0);
         end else begin
            idle();
         end
         exp_pop($sformatf("rr[%0d]", k), il_src[k], il_idx[k], 16'h1000, 16'h2000);
      end

      // ---------------- fill sp, full priority, overflow ----------------
      do_reset();
      lp_j = 0;
      for (int k = 0; k < 11; k++) begin
         cyc(1'b1, mk(3'(k), 16'h3000 + 16'(k)),
             fl_lpv[k] != 0, mk(3'(4 + lp_j), 16'h4000 + 16'(lp_j)), 1'b0);
         if (fl_lpv[k] != 0) lp_j++;
         exp_pop($sformatf("fill[%0d]", k), fl_src[k], fl_idx[k], 16'h3000, 16'h4000);
         chk_eq($sformatf("fill[%0d].sp_almost_full", k), 64'(sp_almost_full), 64'(fl_spaf[k]));
         chk_eq($sformatf("fill[%0d].lp_almost_full", k), 64'(lp_almost_full), 64'(fl_lpaf[k]));
         chk_eq($sformatf("fill[%0d].overflow_err", k), 64'(overflow_err), 64'(fl_ovf[k]));
      end
      idle();
      idle();
      chk_eq("fill.sticky.overflow_err", 64'(overflow_err), 64'd1);
      do_reset();
      chk_eq("fill.cleared.overflow_err", 64'(overflow_err), 64'd0);

      // ---------------- flush with both queues at 2 ----------------
      do_reset();
      for (int k = 0; k < 3; k++) begin
         cyc(1'b1, mk(3'(k), 16'h1000 + 16'(k)),
             1'b1, mk(3'(4 + k), 16'h2000 + 16'(k)), 1'b0);
         exp_pop($sformatf("flush.pre[%0d]", k), il_src[k], il_idx[k], 16'h1000, 16'h2000);
      end
      chk_eq("flush.pre.sp_count", 64'(dut.w_count[0]), 64'd2);
      chk_eq("flush.pre.lp_count", 64'(dut.w_count[1]), 64'd2);
      cyc(1'b1, mk(3'd1, 16'h3009), 1'b0, '0, 1'b1);
      chk_eq("flush.n1.rob_valid", 64'(rob_valid), 64'd0);
      chk_eq("flush.n1.sp_count",  64'(dut.w_count[0]), 64'd0);
      chk_eq("flush.n1.lp_count",  64'(dut.w_count[1]), 64'd0);
      chk_eq("flush.n1.overflow_err", 64'(overflow_err), 64'd0);
      idle();
      chk_eq("flush.n2.rob_valid", 64'(rob_valid), 64'd0);
      idle();
      chk_eq("flush.n3.rob_valid", 64'(rob_valid), 64'd0);
      cyc(1'b1, mk(3'd7, 16'h7777), 1'b0, '0, 1'b0);
      chk_eq("flush.n4.rob_valid", 64'(rob_valid), 64'd0);
      idle();
      exp_rob("flush.n5", 1'b1, 1'b0, 3'd7, 16'h7777);

      // ---------------- pointer wrap, 10 lp pushes ----------------
      do_reset();
      for (int k = 0; k < 11; k++) begin
         if (k < 10) begin
            cyc(1'b0, '0, 1'b1, mk(3'(k), 16'h6000 + 16'(k)), 1'b0);
         end else begin
            idle();
         end
         if (k == 0) begin
            chk_eq("wrap[0].rob_valid", 64'(rob_valid), 64'd0);
         end else begin
            exp_rob($sformatf("wrap[%0d]", k), 1'b1, 1'b1, 3'(k - 1), 16'h6000 + 16'(k - 1));
         end
      end
      chk_eq("wrap.overflow_err",   64'(overflow_err), 64'd0);
      chk_eq("wrap.lp_almost_full", 64'(lp_almost_full), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_rob_wb_port_arbiter
